// File: rtl/muls_m3q3.sv
// 3x3 signed sequential multiplier behind the 8-in/8-out tile pin map.
// Free-running LOAD/IT0/IT1/IT2 schedule; one product every 4 clocks.
module muls_m3q3 (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {S_LOAD, S_IT0, S_IT1, S_IT2} state_t;

  logic       w_clk, w_rst;
  logic [2:0] w_x, w_y;
  logic [5:0] w_final;

  state_t     r_state;
  logic [5:0] r_x, r_acc, r_p;
  logic [2:0] r_y;
  logic       r_s, r_rdy;

  assign w_clk = io_in[0];
  assign w_rst = io_in[1];
  assign w_x   = io_in[4:2];
  assign w_y   = io_in[7:5];

  // y[2] carries weight -4, so the last partial product is subtracted.
  assign w_final = r_acc - (r_y[2] ? (r_x << 2) : 6'd0);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= S_LOAD;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_s     <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_x     <= {{3{w_x[2]}}, w_x};
          r_y     <= w_y;
          r_acc   <= '0;
          r_rdy   <= 1'b0;
          r_state <= S_IT0;
        end
        S_IT0: begin
          r_acc   <= r_acc + (r_y[0] ? r_x : 6'd0);
          r_state <= S_IT1;
        end
        S_IT1: begin
          r_acc   <= r_acc + (r_y[1] ? (r_x << 1) : 6'd0);
          r_state <= S_IT2;
        end
        default: begin
          r_acc   <= w_final;
          r_p     <= w_final;
          r_s     <= w_final[5];
          r_rdy   <= 1'b1;
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign io_out = {r_rdy, r_s, r_p};

endmodule

// File: tb/tb_muls_m3q3.sv
// Scoreboard bench for muls_m3q3: stimulus pushes exact signed products,
// a monitor checks rdy cadence, p/s on each rdy, and hold between results.
module tb_muls_m3q3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] x = '0, y = '0;
  logic [7:0] io_in, io_out;

  int tests = 0;
  int fails = 0;
  logic [5:0] q[$];

  assign io_in = {y, x, rst, clk};

  muls_m3q3 dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  function automatic logic [5:0] model(input logic [2:0] a, input logic [2:0] b);
    int pa, pb;
    pa = int'($signed(a));
    pb = int'($signed(b));
    return 6'(pa * pb);
  endfunction

  // Monitor: rst sampled at the edge, outputs checked 1ns later.
  int         since_rst = 0;
  logic [5:0] hold = '0;
  initial begin
    forever begin
      logic rst_e;
      logic exp_rdy;
      logic [5:0] exp_p;
      @(posedge clk);
      rst_e = rst;
      #1;
      if (rst_e) begin
        since_rst = 0;
        hold = '0;
        q.delete();
        tests++;
        if (io_out !== 8'h00) begin
          fails++;
          $display("FAIL reset_out got=%b want=00000000", io_out);
        end
      end else begin
        since_rst++;
        exp_rdy = (since_rst % 4 == 0);
        tests++;
        if (io_out[7] !== exp_rdy) begin
          fails++;
          $display("FAIL rdy_timing edge=%0d got=%b want=%b", since_rst, io_out[7], exp_rdy);
        end
        if (io_out[7] === 1'b1) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result got p=%b want none", io_out[5:0]);
          end else begin
            exp_p = q.pop_front();
            hold = exp_p;
          end
        end
        tests++;
        if (io_out[6:0] !== {hold[5], hold}) begin
          fails++;
          $display("FAIL product got p=%b s=%b want p=%b s=%b",
                   io_out[5:0], io_out[6], hold, hold[5]);
        end
      end
    end
  end

  // Called at the negedge before a LOAD edge; returns at the negedge after IT2.
  task automatic op(input logic [2:0] a, input logic [2:0] b, input bit scr);
    x = a;
    y = b;
    q.push_back(model(a, b));
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (scr) begin
        x = 3'($urandom);
        y = 3'($urandom);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Idle outputs before the first result are covered by the monitor.
    op(3'd3, 3'd3, 1'b0);
    op(3'b100, 3'b100, 1'b0);
    op(3'd3, 3'b100, 1'b0);
    op(3'd0, 3'b100, 1'b0);
    op(3'b111, 3'd1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      op(v[2:0], v[5:3], 1'b0);
    end
    for (int i = 0; i < 40; i++)
      op(3'($urandom), 3'($urandom), 1'b1);

    // Reset during IT1: in-flight product discarded.
    x = 3'd3; y = 3'd2;
    q.push_back(model(3'd3, 3'd2));
    @(posedge clk); @(negedge clk);   // LOAD
    x = 3'd1; y = 3'd1;
    @(posedge clk); @(negedge clk);   // IT0
    rst = 1'b1;
    @(posedge clk); @(negedge clk);   // IT1 edge under reset
    rst = 1'b0;
    op(3'b101, 3'd3, 1'b1);
    op(3'd2, 3'b110, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_results got=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
